seq_multiplier: RTL and testbench

//  - Parametrised sequential shift-add multiplier (radix-2); successor to the 4-bit combinational multiplier.
//  - Computes P = A * B over WIDTH cycles using one adder, trading latency for area.
//  - Valid/ready on input and output; one operation in flight.
//  - Sits between an operand producer (e.g. an ALU issue stage) and a result consumer.

---
 rtl/seq_multiplier.sv | 84 ++++++++
 tb/tb_seq_multiplier.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, WIDTH cycles per product, valid/ready handshakes.
// Optional two's-complement mode (tc port) enabled by defining SEQ_MUL_SIGNED_EN.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               tc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc, mcand, sum;
    logic [WIDTH-1:0]   mult, a_mag, b_mag;
    logic [CNT_W-1:0]   cnt;
    logic               neg, neg_in, last, accept;

`ifdef SEQ_MUL_SIGNED_EN
    // Magnitudes fit in WIDTH unsigned bits, including the most-negative operand.
    assign a_mag  = (tc && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (tc && B[WIDTH-1]) ? -B : B;
    assign neg_in = tc && (A[WIDTH-1] ^ B[WIDTH-1]);
`else
    assign a_mag  = A;
    assign b_mag  = B;
    assign neg_in = 1'b0;
`endif

    assign accept    = (state == IDLE) && in_valid;
    assign last      = cnt == CNT_W'(WIDTH - 1);
    assign sum       = acc + (mult[0] ? mcand : '0);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? CALC : IDLE;
            CALC:    state_next = last ? DONE : CALC;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right, so bit cnt of B is always mult[0].
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            P     <= '0;
        end else if (accept) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mult  <= b_mag;
            cnt   <= '0;
            neg   <= neg_in;
        end else if (state == CALC) begin
            acc   <= sum;
            mcand <= mcand << 1;
            mult  <= mult >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last) P <= neg ? -sum : sum;
        end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed table plus random ops against an arithmetic reference model,
// for a WIDTH=4 and a WIDTH=8 instance.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, tc = 1'b0;
    logic [3:0]  A = '0, B = '0;
    logic        in_ready, out_valid, busy;
    logic [7:0]  P;
    logic        iv8 = 1'b0, or8 = 1'b0, tc8 = 1'b0;
    logic [7:0]  A8 = '0, B8 = '0;
    logic        ir8, ov8, busy8;
    logic [15:0] P8;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
`ifdef SEQ_MUL_SIGNED_EN
        .tc(tc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(A8), .B(B8),
`ifdef SEQ_MUL_SIGNED_EN
        .tc(tc8),
`endif
        .out_valid(ov8), .out_ready(or8), .P(P8), .busy(busy8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       t;
        int         hold;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic t);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
`ifdef SEQ_MUL_SIGNED_EN
        if (t) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end
`endif
        return 8'(sa * sb);
    endfunction

    // Issue one op on the 4-bit DUT, hold out_ready low for 'hold' cycles, then handshake.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic t, input int hold,
                       output logic [7:0] p);
        int lat;
        @(negedge clk);
        check("idle_in_ready", {15'd0, in_ready}, 16'd1);
        A = a; B = b; tc = t; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = 4'($urandom); B = 4'($urandom); tc = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 16'(lat), 16'd4);
        p = P;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_p_stable", {8'd0, P}, {8'd0, p});
            check("bp_in_ready", {14'd0, in_ready, out_valid}, 16'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_hs", {14'd0, out_valid, in_ready}, 16'd1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        @(negedge clk);
        A8 = a; B8 = b; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        A8 = 8'($urandom); B8 = 8'($urandom);
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", 16'(lat), 16'd8);
        check("p8", P8, 16'(int'(a) * int'(b)));
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check("after_hs8", {14'd0, ov8, ir8}, 16'd1);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [7:0]  p;
        logic [3:0]  ra, rb;
        logic        rt;
        vecs.push_back('{4'd0,  4'd0,  1'b0, 0, 8'h00});
        vecs.push_back('{4'd13, 4'd4,  1'b0, 0, 8'd52});
        vecs.push_back('{4'd10, 4'd10, 1'b0, 0, 8'd100});
        vecs.push_back('{4'd15, 4'd15, 1'b0, 0, 8'd225});
        vecs.push_back('{4'd2,  4'd3,  1'b0, 5, 8'd6});
        vecs.push_back('{4'hD,  4'd5,  1'b0, 1, 8'd65});
        vecs.push_back('{4'd1,  4'd15, 1'b0, 0, 8'd15});
        vecs.push_back('{4'd8,  4'd1,  1'b0, 0, 8'd8});
`ifdef SEQ_MUL_SIGNED_EN
        vecs.push_back('{4'hD,  4'd5,  1'b1, 0, 8'hF1});
        vecs.push_back('{4'h8,  4'h8,  1'b1, 0, 8'h40});
        vecs.push_back('{4'h7,  4'h8,  1'b1, 0, 8'hC8});
`endif
        #1;
        check("rst_p", {8'd0, P}, 16'd0);
        check("rst_flags", {13'd0, out_valid, busy, ov8}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {14'd0, in_ready, ir8}, 16'd3);

        foreach (vecs[i]) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].hold, p);
            check($sformatf("vec%0d", i), {8'd0, p}, {8'd0, vecs[i].exp});
        end

        // Reset two cycles into CALC: no partial result, then a clean op.
        @(negedge clk);
        A = 4'd15; B = 4'd15; tc = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_p", {8'd0, P}, 16'd0);
        check("midrst_flags", {14'd0, out_valid, busy}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midrst_idle", {14'd0, out_valid, in_ready}, 16'd1);
        end
        op4(4'd7, 4'd9, 1'b0, 0, p);
        check("post_rst_op", {8'd0, p}, 16'd63);

        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rt = 1'($urandom);
            op4(ra, rb, rt, int'($urandom_range(0, 2)), p);
            check("rand4", {8'd0, p}, {8'd0, model4(ra, rb, rt)});
        end

        op8(8'd255, 8'd255);
        op8(8'd0, 8'd0);
        for (int i = 0; i < 100; i++) op8(8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end
endmodule
